// File: rtl/can_defs.sv
// Shared CAN definitions: receiver state encoding, field lengths,
// error-code bit positions and the CRC-15 update step.
package can_defs;

    typedef enum logic [3:0] {
        ST_SYNC,
        ST_IDLE,
        ST_ID,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK_SLOT,
        ST_ACK_DEL,
        ST_EOF,
        ST_INTERM
    } rx_state_e;

    localparam logic [14:0] CRC_POLY = 15'h4599;

    localparam logic [6:0] ID_LEN  = 7'd11;
    localparam logic [6:0] DLC_LEN = 7'd4;
    localparam logic [6:0] CRC_LEN = 7'd15;
    localparam logic [6:0] EOF_LEN = 7'd7;

    localparam int ERR_FORM  = 2;
    localparam int ERR_CRC   = 1;
    localparam int ERR_STUFF = 0;

    function automatic logic [14:0] crc15_next(input logic [14:0] crc,
                                               input logic       b);
        logic [14:0] r;
        r = {crc[13:0], 1'b0};
        if (b ^ crc[14]) r = r ^ CRC_POLY;
        return r;
    endfunction

endpackage

// File: rtl/can_rx_destuff.sv
// CAN bit destuffer: drops the bit after five equal bits and
// flags a stuff error when that bit does not toggle.
module can_rx_destuff (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_point,
    input  logic rx_bit,
    input  logic enable,
    input  logic clear,
    output logic data_bit,
    output logic data_valid,
    output logic stuff_err
);

    logic [2:0] run_q, run_d;
    logic       last_q, last_d;
    logic       stuff_slot;

    always_comb begin
        run_d      = run_q;
        last_d     = last_q;
        stuff_slot = (run_q == 3'd5);
        data_bit   = rx_bit;
        data_valid = sample_point && enable && !stuff_slot;
        stuff_err  = sample_point && enable && stuff_slot
                     && (rx_bit == last_q);
        // Clear accounts for the dominant SOF as the first bit of a run
        if (clear) begin
            run_d  = 3'd1;
            last_d = 1'b0;
        end else if (sample_point && enable) begin
            if (stuff_slot || rx_bit != last_q) run_d = 3'd1;
            else                                run_d = run_q + 3'd1;
            last_d = rx_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 3'd0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/can_rx_frame.sv
// CAN 2.0A standard-frame receiver: destuffs, parses, checks CRC and
// form, drives the ACK slot and presents the frame in registers.
module can_rx_frame
    import can_defs::*;
#(
    parameter int IDLE_BITS    = 11,
    parameter int INTERMISSION = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_point,
    input  logic        rx_bit,
    output logic        tx_ack,
    output logic        rx_busy,
    output logic        rx_valid,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        rx_error,
    output logic [2:0]  err_code
);

    rx_state_e   state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [14:0] crc_q, crc_d;
    logic [14:0] crc_rx_q, crc_rx_d;
    logic        crc_ok_q, crc_ok_d;
    logic [10:0] id_s_q, id_s_d;
    logic        rtr_s_q, rtr_s_d;
    logic [3:0]  dlc_s_q, dlc_s_d;
    logic [63:0] data_s_q, data_s_d;
    logic        tx_ack_q, tx_ack_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [10:0] id_q, id_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;

    logic        sof;
    logic [2:0]  err;
    logic [3:0]  dbytes;
    logic [6:0]  data_last;
    logic [3:0]  dlc_new;
    logic        ds_en, ds_bit, ds_valid, ds_err;

    assign ds_en = state_q inside {ST_ID, ST_CTRL, ST_DATA, ST_CRC};

    can_rx_destuff u_destuff (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .enable       (ds_en),
        .clear        (sof),
        .data_bit     (ds_bit),
        .data_valid   (ds_valid),
        .stuff_err    (ds_err)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        crc_rx_d   = crc_rx_q;
        crc_ok_d   = crc_ok_q;
        id_s_d     = id_s_q;
        rtr_s_d    = rtr_s_q;
        dlc_s_d    = dlc_s_q;
        data_s_d   = data_s_q;
        tx_ack_d   = tx_ack_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        id_d       = id_q;
        rtr_d      = rtr_q;
        dlc_d      = dlc_q;
        data_d     = data_q;
        sof        = 1'b0;
        err        = 3'b000;
        err[ERR_STUFF] = ds_err;
        dbytes     = dlc_s_q[3] ? 4'd8 : dlc_s_q;
        data_last  = {dbytes, 3'b000} - 7'd1;
        dlc_new    = {dlc_s_q[2:0], ds_bit};

        if (sample_point) begin
            unique case (state_q)
                ST_SYNC: begin
                    if (!rx_bit) begin
                        cnt_d = 7'd0;
                    end else if (cnt_q == 7'(IDLE_BITS - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = 7'd0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                ST_IDLE: begin
                    if (!rx_bit) sof = 1'b1;
                end
                ST_ID: begin
                    if (ds_valid) begin
                        id_s_d = {id_s_q[9:0], ds_bit};
                        crc_d  = crc15_next(crc_q, ds_bit);
                        if (cnt_q == ID_LEN - 7'd1) begin
                            state_d = ST_CTRL;
                            cnt_d   = 7'd0;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                ST_CTRL: begin
                    if (ds_valid) begin
                        crc_d = crc15_next(crc_q, ds_bit);
                        cnt_d = cnt_q + 7'd1;
                        if (cnt_q == 7'd0)      rtr_s_d = ds_bit;
                        else if (cnt_q == 7'd1) err[ERR_FORM] = ds_bit;
                        else if (cnt_q >= 7'd3) dlc_s_d = dlc_new;
                        if (cnt_q == DLC_LEN + 7'd2) begin
                            cnt_d = 7'd0;
                            if (rtr_s_q || dlc_new == 4'd0) state_d = ST_CRC;
                            else                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (ds_valid) begin
                        data_s_d[6'd63 - cnt_q[5:0]] = ds_bit;
                        crc_d = crc15_next(crc_q, ds_bit);
                        if (cnt_q == data_last) begin
                            state_d = ST_CRC;
                            cnt_d   = 7'd0;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                ST_CRC: begin
                    if (ds_valid) begin
                        crc_rx_d = {crc_rx_q[13:0], ds_bit};
                        if (cnt_q == CRC_LEN - 7'd1) begin
                            crc_ok_d = (crc_rx_d == crc_q);
                            state_d  = ST_CRC_DEL;
                            cnt_d    = 7'd0;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
                ST_CRC_DEL: begin
                    if (!rx_bit) begin
                        err[ERR_FORM] = 1'b1;
                    end else begin
                        tx_ack_d = crc_ok_q;
                        state_d  = ST_ACK_SLOT;
                    end
                end
                ST_ACK_SLOT: begin
                    tx_ack_d = 1'b0;
                    state_d  = ST_ACK_DEL;
                end
                // A CRC mismatch is reported here in place of the form check
                ST_ACK_DEL: begin
                    if (!crc_ok_q)   err[ERR_CRC]  = 1'b1;
                    else if (!rx_bit) err[ERR_FORM] = 1'b1;
                    else begin
                        state_d = ST_EOF;
                        cnt_d   = 7'd0;
                    end
                end
                ST_EOF: begin
                    if (!rx_bit) begin
                        err[ERR_FORM] = 1'b1;
                    end else if (cnt_q == EOF_LEN - 7'd1) begin
                        id_d    = id_s_q;
                        rtr_d   = rtr_s_q;
                        dlc_d   = dlc_s_q;
                        data_d  = data_s_q;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_INTERM;
                        cnt_d   = 7'd0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                ST_INTERM: begin
                    if (!rx_bit) begin
                        sof = 1'b1;
                    end else if (cnt_q == 7'(INTERMISSION - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = 7'd0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                    cnt_d   = 7'd0;
                end
            endcase
        end

        if (sof) begin
            state_d  = ST_ID;
            cnt_d    = 7'd0;
            crc_d    = 15'd0;
            crc_rx_d = 15'd0;
            crc_ok_d = 1'b0;
            id_s_d   = 11'd0;
            rtr_s_d  = 1'b0;
            dlc_s_d  = 4'd0;
            data_s_d = 64'd0;
            busy_d   = 1'b1;
        end

        if (|err) begin
            state_d    = ST_SYNC;
            cnt_d      = 7'd0;
            busy_d     = 1'b0;
            tx_ack_d   = 1'b0;
            error_d    = 1'b1;
            err_code_d = err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SYNC;
            cnt_q      <= 7'd0;
            crc_q      <= 15'd0;
            crc_rx_q   <= 15'd0;
            crc_ok_q   <= 1'b0;
            id_s_q     <= 11'd0;
            rtr_s_q    <= 1'b0;
            dlc_s_q    <= 4'd0;
            data_s_q   <= 64'd0;
            tx_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 3'd0;
            id_q       <= 11'd0;
            rtr_q      <= 1'b0;
            dlc_q      <= 4'd0;
            data_q     <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            crc_rx_q   <= crc_rx_d;
            crc_ok_q   <= crc_ok_d;
            id_s_q     <= id_s_d;
            rtr_s_q    <= rtr_s_d;
            dlc_s_q    <= dlc_s_d;
            data_s_q   <= data_s_d;
            tx_ack_q   <= tx_ack_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            id_q       <= id_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            data_q     <= data_d;
        end
    end

    assign tx_ack   = tx_ack_q;
    assign rx_busy  = busy_q;
    assign rx_valid = valid_q;
    assign rx_id    = id_q;
    assign rx_rtr   = rtr_q;
    assign rx_dlc   = dlc_q;
    assign rx_data  = data_q;
    assign rx_error = error_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_can_rx_frame.sv
// Directed bench for can_rx_frame: builds stuffed frames with a
// reference CRC-15 and checks outputs, pulses and ACK timing.
module tb_can_rx_frame;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_point;
    logic        rx_bit;
    logic        tx_ack;
    logic        rx_busy;
    logic        rx_valid;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        rx_error;
    logic [2:0]  err_code;

    can_rx_frame dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .tx_ack       (tx_ack),
        .rx_busy      (rx_busy),
        .rx_valid     (rx_valid),
        .rx_id        (rx_id),
        .rx_rtr       (rx_rtr),
        .rx_dlc       (rx_dlc),
        .rx_data      (rx_data),
        .rx_error     (rx_error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_errors = 0;
    int       n_valid  = 0;
    int       n_err_p  = 0;
    logic [2:0] last_code = 3'd0;
    int       ack_cnt;
    int       ack_pos;
    logic     stream[$];
    int       crc_del_idx;
    int       eof_idx;
    int       v0, e0;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (rx_error) begin
            n_err_p++;
            last_code = err_code;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] ref_crc(input logic [14:0] c,
                                            input logic b);
        logic [14:0] r;
        r = {c[13:0], 1'b0};
        if (b ^ c[14]) r = r ^ 15'h4599;
        return r;
    endfunction

    task automatic build(input logic [10:0] id, input logic rtr,
                         input logic [3:0] dlc, input logic [63:0] data,
                         input bit bad_crc);
        logic        raw[$];
        logic [14:0] crc;
        int          nb, run;
        logic        last;
        raw = {};
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
        crc = 15'd0;
        foreach (raw[i]) crc = ref_crc(crc, raw[i]);
        if (bad_crc) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        stream = {};
        run  = 0;
        last = raw[0];
        for (int i = 0; i < raw.size(); i++) begin
            stream.push_back(raw[i]);
            if (raw[i] == last) run++;
            else run = 1;
            last = raw[i];
            if (run == 5 && i != raw.size() - 1) begin
                stream.push_back(~raw[i]);
                last = ~raw[i];
                run  = 1;
            end
        end
        crc_del_idx = stream.size();
        repeat (3) stream.push_back(1'b1);
        eof_idx = stream.size();
        repeat (7) stream.push_back(1'b1);
    endtask

    task automatic send_bit(input logic b, input int idx);
        @(negedge clk);
        rx_bit       = b;
        sample_point = 1'b1;
        @(posedge clk);
        #1;
        sample_point = 1'b0;
        if (tx_ack) begin
            ack_cnt++;
            ack_pos = idx;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to; i++) send_bit(stream[i], i);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, -1);
    endtask

    task automatic start_frame();
        v0      = n_valid;
        e0      = n_err_p;
        ack_cnt = 0;
        ack_pos = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        sample_point = 1'b0;
        rx_bit       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", 64'({rx_busy, rx_valid, rx_error, tx_ack,
                                rx_rtr, err_code}), 64'd0);
        check("rst_id", 64'(rx_id), 64'd0);
        check("rst_dlc", 64'(rx_dlc), 64'd0);
        check("rst_data", rx_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_idle(11);

        // Frame 1: good two-byte frame
        build(11'h123, 1'b0, 4'd2, 64'h1122_0000_0000_0000, 1'b0);
        start_frame();
        send_range(0, 5);
        check("f1_busy", 64'(rx_busy), 64'd1);
        send_range(5, stream.size());
        send_idle(3);
        check("f1_valid", 64'(n_valid - v0), 64'd1);
        check("f1_noerr", 64'(n_err_p - e0), 64'd0);
        check("f1_id", 64'(rx_id), 64'h123);
        check("f1_rtr", 64'(rx_rtr), 64'd0);
        check("f1_dlc", 64'(rx_dlc), 64'd2);
        check("f1_data", rx_data, 64'h1122_0000_0000_0000);
        check("f1_ack_cnt", 64'(ack_cnt), 64'd1);
        check("f1_ack_pos", 64'(ack_pos), 64'(crc_del_idx));
        check("f1_idle", 64'(rx_busy), 64'd0);

        // Frame 2: last CRC bit inverted
        build(11'h123, 1'b0, 4'd2, 64'h1122_0000_0000_0000, 1'b1);
        start_frame();
        send_range(0, crc_del_idx + 2);
        check("f2_no_early_err", 64'(n_err_p - e0), 64'd0);
        send_range(crc_del_idx + 2, crc_del_idx + 3);
        check("f2_err", 64'(n_err_p - e0), 64'd1);
        check("f2_code", 64'(last_code), 64'b010);
        check("f2_busy", 64'(rx_busy), 64'd0);
        send_range(crc_del_idx + 3, stream.size());
        send_idle(11);
        check("f2_ack", 64'(ack_cnt), 64'd0);
        check("f2_novalid", 64'(n_valid - v0), 64'd0);
        check("f2_id_held", 64'(rx_id), 64'h123);
        check("f2_data_held", rx_data, 64'h1122_0000_0000_0000);

        // Frame 3: stuff bit after five recessive ID bits kept recessive
        build(11'h7F0, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 1'b0);
        stream[6] = 1'b1;
        start_frame();
        send_range(0, 6);
        check("f3_no_early_err", 64'(n_err_p - e0), 64'd0);
        send_range(6, 7);
        check("f3_err", 64'(n_err_p - e0), 64'd1);
        check("f3_code", 64'(last_code), 64'b001);
        check("f3_busy", 64'(rx_busy), 64'd0);
        send_idle(11);
        build(11'h7F0, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 1'b0);
        start_frame();
        send_range(0, stream.size());
        send_idle(3);
        check("f3b_valid", 64'(n_valid - v0), 64'd1);
        check("f3b_id", 64'(rx_id), 64'h7F0);
        check("f3b_dlc", 64'(rx_dlc), 64'd1);
        check("f3b_data", rx_data, 64'hAA00_0000_0000_0000);

        // Frame 4: DLC 15 receives eight bytes
        build(11'h2A5, 1'b0, 4'hF, 64'h0102_0304_0506_0708, 1'b0);
        start_frame();
        send_range(0, stream.size());
        send_idle(3);
        check("f4_valid", 64'(n_valid - v0), 64'd1);
        check("f4_dlc", 64'(rx_dlc), 64'hF);
        check("f4_data", rx_data, 64'h0102_0304_0506_0708);

        // Frame 5: remote frame, no data field
        build(11'h055, 1'b1, 4'd4, 64'hFFFF_FFFF_0000_0000, 1'b0);
        start_frame();
        send_range(0, stream.size());
        send_idle(3);
        check("f5_valid", 64'(n_valid - v0), 64'd1);
        check("f5_id", 64'(rx_id), 64'h055);
        check("f5_rtr", 64'(rx_rtr), 64'd1);
        check("f5_dlc", 64'(rx_dlc), 64'd4);
        check("f5_data", rx_data, 64'd0);

        // Frame 6: dominant third EOF bit
        build(11'h321, 1'b0, 4'd1, 64'h5500_0000_0000_0000, 1'b0);
        stream[eof_idx + 2] = 1'b0;
        start_frame();
        send_range(0, eof_idx + 3);
        check("f6_err", 64'(n_err_p - e0), 64'd1);
        check("f6_code", 64'(last_code), 64'b100);
        check("f6_novalid", 64'(n_valid - v0), 64'd0);
        check("f6_id_held", 64'(rx_id), 64'h055);
        check("f6_rtr_held", 64'(rx_rtr), 64'd1);
        send_idle(11);

        // Frame 7: reset pulsed in the data field
        build(11'h456, 1'b0, 4'd8, 64'hDEAD_BEEF_0123_4567, 1'b0);
        start_frame();
        send_range(0, 25);
        check("f7_busy", 64'(rx_busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("f7_rst_flags", 64'({rx_busy, rx_valid, rx_error, tx_ack,
                                   rx_rtr, err_code}), 64'd0);
        check("f7_rst_id", 64'(rx_id), 64'd0);
        check("f7_rst_dlc", 64'(rx_dlc), 64'd0);
        check("f7_rst_data", rx_data, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_idle(5);
        start_frame();
        send_range(0, stream.size());
        check("f7_not_synced", 64'(n_valid - v0), 64'd0);
        send_idle(11);
        start_frame();
        send_range(0, stream.size());
        send_idle(3);
        check("f7_valid", 64'(n_valid - v0), 64'd1);
        check("f7_id", 64'(rx_id), 64'h456);
        check("f7_data", rx_data, 64'hDEAD_BEEF_0123_4567);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/can_rx_frame.md
Name: can_rx_frame

Overview:
- Receive-side counterpart of the CAN transmit path (can_top).
- Samples the serial bus bit on each sample_point and removes stuff bits.
- Parses a CAN 2.0A standard data/remote frame, checks CRC-15 and form, drives the ACK slot, and presents the received ID, DLC and data as parallel registers with a one-cycle valid pulse.
- Sits between the bit-timing logic (source of sample_point) and the host-side message buffer.

Parameters:
- IDLE_BITS, 11, consecutive recessive bits required before an SOF is accepted, after reset or after an error.
- INTERMISSION, 3, recessive bits required after EOF before the next SOF is accepted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_point  in  1  one-clk strobe; rx_bit is valid and consumed only in cycles where this is high
- rx_bit  in  1  bus level; 0 = dominant, 1 = recessive
- tx_ack  out  1  1 = drive dominant on the bus (ACK slot only)
- rx_busy  out  1  high from SOF until end of EOF or error
- rx_valid  out  1  one-clk pulse: frame received without error
- rx_id  out  11  identifier
- rx_rtr  out  1  remote-request bit
- rx_dlc  out  4  raw DLC field
- rx_data  out  64  data bytes; byte 0 in [63:56]; unused bytes are 0
- rx_error  out  1  one-clk pulse: frame aborted
- err_code  out  3  {form, crc, stuff}; valid while rx_error is high, otherwise held

Behaviour:
- Reset:
  - All outputs are 0.
  - State is SYNC with the recessive counter at 0.
- Timing:
  - All state advances happen only in cycles with sample_point = 1.
  - Outputs are registered; rx_valid and rx_error assert on the clk edge after the sample_point that completes the frame or detects the error.
- Bit order: every field is MSB first.
- States and transitions:
  - SYNC: count consecutive recessive bits; a dominant bit clears the count. At IDLE_BITS go to IDLE.
  - IDLE: a dominant bit is the SOF. Go to ID, clear the CRC register, set the stuff counter to 1 with last-bit = 0, assert rx_busy.
  - ID (11 bits), then CTRL (RTR, IDE, r0, DLC[3:0]).
  - IDE = 1 is a form error (extended frames are not supported).
  - r0 is ignored.
  - DATA: the byte count is min(DLC,8) when RTR = 0, and 0 when RTR = 1. A zero count skips straight to CRC.
  - CRC: 15 bits.
  - CRC_DEL, ACK_SLOT, ACK_DEL, EOF (7 bits), INTERMISSION, then IDLE.
- Destuffing:
  - Active from SOF through the last CRC bit.
  - After 5 equal consecutive bits (stuff bits included in the run), the next bit is a stuff bit and is discarded.
  - If that stuff bit equals the previous bit, raise a stuff error.
  - A stuff bit starts a new run of length 1.
  - Destuffing is disabled from CRC_DEL onward.
- CRC:
  - CAN CRC-15, polynomial 0x4599, initial value 0.
  - Fed with destuffed bits from SOF through the last data bit.
  - The received 15-bit field is compared with the register at the end of CRC.
- ACK:
  - If the CRC matched, tx_ack = 1 from the clk after the CRC_DEL sample until the clk after the ACK_SLOT sample.
  - Otherwise tx_ack stays 0.
  - A dominant ACK_SLOT is not checked.
- Form errors: a dominant CRC_DEL, ACK_DEL or any EOF bit.
- CRC error:
  - Recorded at the CRC compare; the frame still completes through ACK_DEL.
  - The error is flagged at ACK_DEL instead of a form check. This is intentional: the ACK is withheld and the error is reported after ACK_DEL.
- Any error:
  - Pulse rx_error with the matching err_code bit, deassert rx_busy, go to SYNC.
  - rx_id, rx_dlc and rx_data hold their last good values; partially received fields are never exposed.
- Success:
  - On the 7th EOF bit, copy the shadow ID/RTR/DLC/data into the outputs.
  - Pulse rx_valid and deassert rx_busy.
- DLC values 9..15 are reported raw in rx_dlc; 8 bytes are received.
- A dominant bit during INTERMISSION is treated as the SOF of the next frame (overload frames are not supported).
- Reset mid-frame: immediate return to reset values; the frame is discarded.

Decomposition:
- can_defs package:
  - rx state enum.
  - CRC polynomial constant 0x4599.
  - Field lengths: ID=11, DLC=4, CRC=15, EOF=7.
  - err_code bit indices.
- Sub-module can_rx_destuff: sample-qualified bit in; outputs data_bit, data_valid, stuff_err; enable and clear inputs.
- CRC-15 update is a package function shared with the transmitter.

Test Plan:
- Frame 1: ID 0x123, RTR 0, DLC 2, data 0x11 0x22, correct CRC (from a bench model), stuffing inserted by the bench.
  - Expect rx_valid, rx_id = 0x123, rx_dlc = 2, rx_data = 0x1122_0000_0000_0000.
  - Expect tx_ack high for exactly the ACK slot.
- Frame 1 with the last CRC bit inverted:
  - Expect tx_ack = 0, rx_error with err_code = 3'b010 after ACK_DEL, no rx_valid.
  - Outputs keep their previous values.
- ID 0x7F0 with the stuff bit after the five recessive MSBs forced recessive:
  - Expect rx_error with err_code = 3'b001 at that bit.
  - After 11 recessive bits, a following good frame is received.
- DLC 0xF, data 0x01..0x08:
  - Expect rx_dlc = 0xF, rx_data = 0x0102030405060708.
- RTR = 1 with DLC 4: no data field is consumed; expect rx_rtr = 1, rx_dlc = 4, rx_data = 0.
- Dominant 3rd EOF bit: expect rx_error with err_code = 3'b100.
- rst_n pulsed low mid-DATA: all outputs go to 0; the next frame is accepted only after 11 recessive bits.
